// File: rtl/sram_port_arbiter_if.sv
// One requester port of the SRAM arbiter: a valid/ready request channel
// and a read response channel that has no backpressure.
interface sram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          valid;
    logic          ready;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wem;
    logic          rsp_vld;
    logic [DW-1:0] rsp_dat;

    // Requester side: issues requests and consumes read responses.
    modport master (
        output valid, addr, we, wdata, wem,
        input  ready, rsp_vld, rsp_dat
    );

    // Arbiter side: accepts requests and returns read responses.
    modport slave (
        input  valid, addr, we, wdata, wem,
        output ready, rsp_vld, rsp_dat
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the bus port (b) and the conv core
// port (c). Grants are combinational with zero-cycle request-to-cs latency,
// and read data returns one cycle later to whichever port issued the read.
module sram_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MW       = 4,
    parameter int RR_MODE  = 0,
    parameter int MAX_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_port_arbiter_if.slave     b,
    sram_port_arbiter_if.slave     c,
    output logic                   ram_cs,
    output logic                   ram_we,
    output logic [AW-1:0]          ram_addr,
    output logic [DW-1:0]          ram_din,
    output logic [MW-1:0]          ram_wem,
    input  logic [DW-1:0]          ram_dout,
    output logic                   bus_forced
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    logic       rdPend_q,  rdPend_d;
    logic       rdOwner_q, rdOwner_d;
    logic       lastGnt_q, lastGnt_d;
    logic [7:0] waitCnt_q, waitCnt_d;

    logic gntBus;
    logic gntCore;
    logic forced;

    // Pick the winner: core-priority with a starvation guard, or round-robin
    // biased away from the last winner; nothing is granted while in reset.
    always_comb begin
        gntBus  = 1'b0;
        gntCore = 1'b0;
        forced  = 1'b0;
        if (!rst) begin
            if (RR_MODE == 0) begin
                forced = b.valid & c.valid & (waitCnt_q == MaxWait);
                gntBus = b.valid & (~c.valid | forced);
            end else begin
                gntBus = b.valid & (~c.valid | lastGnt_q);
            end
            gntCore = c.valid & ~gntBus;
        end
    end

    assign b.ready    = gntBus;
    assign c.ready    = gntCore;
    assign bus_forced = forced;

    // Steer the winning request onto the SRAM pins; idle pins are held at 0.
    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        ram_wem  = '0;
        if (gntBus) begin
            ram_cs   = 1'b1;
            ram_we   = b.we;
            ram_addr = b.addr;
            ram_din  = b.wdata;
            ram_wem  = b.wem;
        end else if (gntCore) begin
            ram_cs   = 1'b1;
            ram_we   = c.we;
            ram_addr = c.addr;
            ram_din  = c.wdata;
            ram_wem  = c.wem;
        end
    end

    // Next state: remember who owns the read in flight, how long the bus has
    // been starved, and who won last for round-robin.
    always_comb begin
        rdPend_d  = (gntBus & ~b.we) | (gntCore & ~c.we);
        rdOwner_d = rdOwner_q;
        lastGnt_d = lastGnt_q;
        waitCnt_d = waitCnt_q;
        if (gntBus | gntCore) begin
            rdOwner_d = gntCore;
            lastGnt_d = gntCore;
        end
        if (!b.valid || gntBus) begin
            waitCnt_d = 8'd0;
        end else if (waitCnt_q != MaxWait) begin
            waitCnt_d = waitCnt_q + 8'd1;
        end
    end

    // State registers; reset drops any read that is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPend_q  <= 1'b0;
            rdOwner_q <= 1'b0;
            lastGnt_q <= 1'b1;
            waitCnt_q <= 8'd0;
        end else begin
            rdPend_q  <= rdPend_d;
            rdOwner_q <= rdOwner_d;
            lastGnt_q <= lastGnt_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    assign b.rsp_vld = ~rst & rdPend_q & ~rdOwner_q;
    assign c.rsp_vld = ~rst & rdPend_q & rdOwner_q;
    assign b.rsp_dat = b.rsp_vld ? ram_dout : '0;
    assign c.rsp_dat = c.rsp_vld ? ram_dout : '0;

endmodule
